dummy_instr_gen: RTL

Parametrised dummy-instruction generator for the Ibex-derived core's IF/ID boundary. It inserts pseudo-random, architecturally inert R-type instructions (rd = x0) into the instruction stream to decorrelate timing and power from program flow. Compared with the single-shot inserter, it adds:
- a configurable LFSR width and counter width;
- a fixed-interval mode and a burst mode;
- a registered per-gap threshold;
- a saturating statistics counter.

---
 rtl/dummy_instr_gen.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/dummy_instr_gen.sv
// Dummy-instruction generator: inserts inert R-type (rd = x0) instructions at the IF/ID boundary.
// Build macro DUMMY_INSTR_MULDIV_EN selects MUL/DIV instead of SUB/XOR for two of the four operations.
module dummy_instr_gen #(
    parameter int unsigned       LFSR_W    = 32,
    parameter int unsigned       CNT_W     = 5,
    parameter int unsigned       MAX_BURST = 4,
    parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(32'hAC533BF4)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              en_i,
    input  logic [1:0]        mode_i,
    input  logic [CNT_W-3:0]  mask_i,
    input  logic [CNT_W-1:0]  interval_i,
    input  logic              seed_en_i,
    input  logic [LFSR_W-1:0] seed_i,
    input  logic              fetch_valid_i,
    input  logic              id_in_ready_i,
    output logic              insert_o,
    output logic [31:0]       instr_o,
    input  logic              count_clr_i,
    output logic [15:0]       count_o
);
    // state    | meaning
    // S_COUNT  | counting real instructions until cnt reaches the gap threshold
    // S_INSERT | presenting the remaining dummies of the current burst

    localparam int unsigned SEL_W = $clog2(MAX_BURST);
    localparam int unsigned BL_W  = SEL_W + 1;
    localparam logic [LFSR_W-1:0] TAPS = (LFSR_W == 64) ? LFSR_W'(64'hD800000000000000)
                                                        : LFSR_W'(32'h80200003);

    typedef enum logic {S_COUNT, S_INSERT} state_e;

    state_e            r_state, w_state_nxt;
    logic [LFSR_W-1:0] r_lfsr, r_seed;
    logic [CNT_W-1:0]  r_cnt, r_thr;
    logic [BL_W-1:0]   r_burst_left;
    logic [15:0]       r_count;

    logic [LFSR_W-1:0] w_seed_mix, w_lfsr_step, w_lfsr_nxt;
    logic [CNT_W-1:0]  w_thr;
    logic [BL_W-1:0]   w_burst_rand, w_burst_cur;
    logic              w_hit, w_insert, w_consume, w_last, w_abort;
    logic [6:0]        w_f7;
    logic [2:0]        w_f3;

    if (SEL_W > 0) begin : g_burst_rand
        assign w_burst_rand = BL_W'(r_lfsr[20 +: SEL_W]) + BL_W'(1);
    end else begin : g_burst_single
        assign w_burst_rand = BL_W'(1);
    end

    assign w_seed_mix  = r_seed ^ seed_i;
    assign w_lfsr_step = r_lfsr[0] ? ((r_lfsr >> 1) ^ TAPS) : (r_lfsr >> 1);

    // A reseed overrides a same-cycle step; an all-zero mix would lock the LFSR.
    always_comb begin
        w_lfsr_nxt = r_lfsr;
        if (seed_en_i) begin
            w_lfsr_nxt = (w_seed_mix == '0) ? SEED : w_seed_mix;
        end else if (w_consume) begin
            w_lfsr_nxt = w_lfsr_step;
        end
    end

    always_comb begin
        w_thr = r_thr & {mask_i, 2'b11};
        if (mode_i == 2'b01) begin
            w_thr = interval_i;
        end
    end

    assign w_hit = en_i & (r_cnt == w_thr);

    always_comb begin
        w_state_nxt = r_state;
        w_insert    = 1'b0;
        w_burst_cur = r_burst_left;
        w_abort     = 1'b0;
        case (r_state)
            S_COUNT: begin
                w_insert    = w_hit;
                w_burst_cur = (mode_i == 2'b10) ? w_burst_rand : BL_W'(1);
            end
            S_INSERT: begin
                w_insert = en_i;
                w_abort  = ~en_i;
            end
            default: ;
        endcase
        w_consume = w_insert & id_in_ready_i;
        w_last    = w_consume & (w_burst_cur == BL_W'(1));
        if (w_abort || w_last) begin
            w_state_nxt = S_COUNT;
        end else if (w_insert) begin
            w_state_nxt = S_INSERT;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state      <= S_COUNT;
            r_lfsr       <= SEED;
            r_seed       <= '0;
            r_cnt        <= '0;
            r_thr        <= '1;
            r_burst_left <= BL_W'(1);
            r_count      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (seed_en_i) begin
                r_seed <= w_seed_mix;
            end
            if (seed_en_i || w_consume) begin
                r_lfsr <= w_lfsr_nxt;
            end
            if (w_abort || w_last) begin
                r_cnt <= '0;
            end else if (r_state == S_COUNT && en_i && !w_insert && fetch_valid_i && id_in_ready_i) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            if (w_last) begin
                r_thr <= w_lfsr_nxt[CNT_W-1:0];
            end
            if (w_insert && !w_last) begin
                r_burst_left <= w_consume ? (w_burst_cur - BL_W'(1)) : w_burst_cur;
            end
            if (count_clr_i) begin
                r_count <= '0;
            end else if (w_consume && r_count != 16'hFFFF) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    always_comb begin
        w_f7 = 7'b0000000;
        w_f3 = 3'b000;
        case (r_lfsr[16:15])
`ifdef DUMMY_INSTR_MULDIV_EN
            2'b01: begin w_f7 = 7'b0000001; w_f3 = 3'b000; end
            2'b10: begin w_f7 = 7'b0000001; w_f3 = 3'b100; end
`else
            2'b01: begin w_f7 = 7'b0100000; w_f3 = 3'b000; end
            2'b10: begin w_f7 = 7'b0000000; w_f3 = 3'b100; end
`endif
            2'b11: begin w_f7 = 7'b0000000; w_f3 = 3'b111; end
            default: ;
        endcase
    end

    assign insert_o = w_insert;
    assign instr_o  = {w_f7, r_lfsr[14:10], r_lfsr[9:5], w_f3, 5'b00000, 7'b0110011};
    assign count_o  = r_count;

endmodule
